// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: builds a 32-bit little-endian instruction from four
// byte reads. A one-entry buffer serves repeated requests for the same pc.
module inst_fetch_resp #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_ce,
  input  logic              i_jumpout,
  input  logic [7:0]        i_mem_din,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd_en,
  output logic [INST_W-1:0] o_inst,
  output logic              o_inst_valid,
  output logic              o_stall_req
);

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StRd2,
    StRd3,
    StLast
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_req_pc;
  logic [ADDR_W-1:0]   w_req_pc_nxt;
  logic [ADDR_W-1:0]   r_tag;
  logic                r_tag_valid;
  logic [INST_W-1:0]   r_buf;
  logic [INST_W-1:0]   r_shadow;
  logic [ADDR_W-1:0]   w_offset;
  logic                w_rd_en;
  logic                w_hit;
  logic                w_abort;
  logic                w_commit;

  assign w_hit    = i_ce & r_tag_valid & (i_pc == r_tag) & (r_state == StIdle);
  assign w_abort  = (r_state != StIdle) & (i_jumpout | ~i_ce);
  assign w_commit = (r_state == StLast) & ~w_abort;

  always_comb begin
    w_state_nxt  = r_state;
    w_req_pc_nxt = r_req_pc;
    w_rd_en      = 1'b0;
    w_offset     = '0;
    unique case (r_state)
      StIdle: begin
        if (i_ce & ~w_hit) begin
          w_state_nxt  = StRd0;
          w_req_pc_nxt = i_pc;
        end
      end
      StRd0: begin
        w_rd_en     = 1'b1;
        w_offset    = ADDR_W'(0);
        w_state_nxt = StRd1;
      end
      StRd1: begin
        w_rd_en     = 1'b1;
        w_offset    = ADDR_W'(1);
        w_state_nxt = StRd2;
      end
      StRd2: begin
        w_rd_en     = 1'b1;
        w_offset    = ADDR_W'(2);
        w_state_nxt = StRd3;
      end
      StRd3: begin
        w_rd_en     = 1'b1;
        w_offset    = ADDR_W'(3);
        w_state_nxt = StLast;
      end
      StLast: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
    // Abort wins over everything, including the commit in StLast.
    if (w_abort) begin
      w_state_nxt = StIdle;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= StIdle;
      r_req_pc <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_req_pc <= w_req_pc_nxt;
    end
  end

  // mem_din carries the byte addressed one cycle earlier, hence the one-state lag.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_shadow <= '0;
    end else begin
      case (r_state)
        StRd1:   r_shadow[7:0]   <= i_mem_din;
        StRd2:   r_shadow[15:8]  <= i_mem_din;
        StRd3:   r_shadow[23:16] <= i_mem_din;
        StLast:  r_shadow[31:24] <= i_mem_din;
        default: r_shadow        <= r_shadow;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_buf       <= '0;
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
    end else if (w_commit) begin
      r_buf       <= {i_mem_din, r_shadow[23:0]};
      r_tag       <= r_req_pc;
      r_tag_valid <= 1'b1;
    end
  end

  assign o_mem_rd_en  = w_rd_en;
  assign o_mem_addr   = w_rd_en ? (r_req_pc + w_offset) : '0;
  assign o_inst_valid = w_hit;
  assign o_inst       = w_hit ? r_buf : '0;
  // Gated by reset so the stall request drops immediately on an asynchronous reset.
  assign o_stall_req  = i_rst & i_ce & ~w_hit;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: directed plan steps then random traffic, all checked
// cycle by cycle against a transaction-level model of the fetch buffer.
module tb_inst_fetch_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        ce = 1'b0;
  logic        jumpout = 1'b0;
  logic [7:0]  mem_din = '0;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall_req;

  int n_cmp  = 0;
  int n_fail = 0;

  inst_fetch_resp #(.ADDR_W(32), .INST_W(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pc        (pc),
    .i_ce        (ce),
    .i_jumpout   (jumpout),
    .i_mem_din   (mem_din),
    .o_mem_addr  (mem_addr),
    .o_mem_rd_en (mem_rd_en),
    .o_inst      (inst),
    .o_inst_valid(inst_valid),
    .o_stall_req (stall_req)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'h0: return 8'h13;
      32'h1: return 8'h05;
      32'h2: return 8'h10;
      32'h3: return 8'h00;
      32'h4: return 8'h93;
      32'h5: return 8'h05;
      32'h6: return 8'h20;
      32'h7: return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  // Byte-wide memory: data for the address presented this cycle appears next cycle.
  always @(posedge clk) begin
    if (mem_rd_en) mem_din <= mb(mem_addr);
  end

  // Reference model: a fetch in flight is (req, cycle index 1..5 after the miss).
  logic        m_busy = 1'b0;
  int          m_k = 0;
  logic [31:0] m_req = '0;
  logic        m_tv = 1'b0;
  logic [31:0] m_tag = '0;
  logic [31:0] m_buf = '0;

  // Observation records
  int          stall_cnt;
  int          n_valid;
  int          n_rd;
  logic [31:0] addr_q[$];
  logic        seen_valid;
  logic [31:0] last_inst;
  logic        last_valid;
  logic        last_rd;
  logic        last_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hit();
    return ce && m_tv && (pc == m_tag) && !m_busy;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_k    = 0;
    m_tv   = 1'b0;
    m_tag  = '0;
    m_buf  = '0;
  endtask

  task automatic check_outputs();
    logic        h;
    logic        e_rd;
    logic [31:0] e_addr;
    h      = rst && model_hit();
    e_rd   = rst && m_busy && (m_k <= 4);
    e_addr = e_rd ? m_req + 32'(m_k - 1) : 32'h0;
    check("mem_rd_en", {31'h0, mem_rd_en}, {31'h0, e_rd});
    check("mem_addr", mem_addr, e_addr);
    check("inst_valid", {31'h0, inst_valid}, {31'h0, h});
    check("inst", inst, h ? m_buf : 32'h0);
    check("stall_req", {31'h0, stall_req}, {31'h0, rst && ce && !h});
    if (stall_req) stall_cnt++;
    if (mem_rd_en) begin
      n_rd++;
      addr_q.push_back(mem_addr);
    end
    if (inst_valid) begin
      n_valid++;
      seen_valid = 1'b1;
      last_inst  = inst;
    end
    last_valid = inst_valid;
    last_rd    = mem_rd_en;
    last_stall = stall_req;
  endtask

  task automatic model_step();
    logic h;
    h = model_hit();
    if (!m_busy) begin
      if (ce && !h) begin
        m_busy = 1'b1;
        m_req  = pc;
        m_k    = 1;
      end
    end else if (jumpout || !ce) begin
      m_busy = 1'b0;
    end else if (m_k == 5) begin
      m_tag  = m_req;
      m_tv   = 1'b1;
      m_buf  = {mb(m_req + 32'd3), mb(m_req + 32'd2), mb(m_req + 32'd1), mb(m_req)};
      m_busy = 1'b0;
    end else begin
      m_k++;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  task automatic clear_rec();
    stall_cnt  = 0;
    n_valid    = 0;
    n_rd       = 0;
    addr_q     = {};
    seen_valid = 1'b0;
  endtask

  task automatic wait_hit(input string tag);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (seen_valid) break;
    end
    check({tag, "_hit_seen"}, {31'h0, seen_valid}, 32'h1);
  endtask

  initial begin
    clear_rec();
    // Reset values
    #2;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: cold miss at pc 0
    ce = 1'b1;
    pc = 32'h0;
    clear_rec();
    wait_hit("cold");
    check("cold_stall_cycles", stall_cnt, 32'd6);
    check("cold_nbytes", addr_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++) check("cold_addr", addr_q[i], 32'(i));
    check("cold_inst", last_inst, 32'h00100513);

    // 2: hits with pc held
    clear_rec();
    repeat (5) cyc();
    check("hit_valid_cnt", n_valid, 32'd5);
    check("hit_rd_cnt", n_rd, 32'd0);

    // 3: new pc drops valid immediately
    pc = 32'h4;
    clear_rec();
    cyc();
    check("newpc_valid_drop", {31'h0, last_valid}, 32'h0);
    wait_hit("newpc");
    check("newpc_stall_cycles", stall_cnt, 32'd6);
    check("newpc_inst", last_inst, 32'h00200593);

    // 4: jump abort during RD2
    pc = 32'h8;
    clear_rec();
    repeat (3) cyc();
    jumpout = 1'b1;
    pc      = 32'h0;
    cyc();
    check("abort_cycle_rd", {31'h0, last_rd}, 32'h1);
    check("abort_cycle_addr", addr_q[addr_q.size()-1], 32'hA);
    jumpout = 1'b0;
    cyc();
    check("abort_next_rd", {31'h0, last_rd}, 32'h0);
    check("abort_next_valid", {31'h0, last_valid}, 32'h0);
    check("abort_next_stall", {31'h0, last_stall}, 32'h1);
    clear_rec();
    wait_hit("refetch");
    check("refetch_inst", last_inst, 32'h00100513);

    // 5: address wrap-around
    pc = 32'hFFFF_FFFE;
    clear_rec();
    wait_hit("wrap");
    check("wrap_nbytes", addr_q.size(), 32'd4);
    if (addr_q.size() == 4) begin
      check("wrap_addr0", addr_q[0], 32'hFFFF_FFFE);
      check("wrap_addr1", addr_q[1], 32'hFFFF_FFFF);
      check("wrap_addr2", addr_q[2], 32'h0000_0000);
      check("wrap_addr3", addr_q[3], 32'h0000_0001);
    end
    check("wrap_inst", last_inst, 32'h05135A5B);

    // 6: asynchronous reset during RD1
    pc = 32'h0;
    clear_rec();
    repeat (2) cyc();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
    check("rst_stall", {31'h0, stall_req}, 32'h0);
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    cyc();
    rst = 1'b1;
    cyc();
    check("post_rst_valid", {31'h0, last_valid}, 32'h0);
    check("post_rst_stall", {31'h0, last_stall}, 32'h1);
    clear_rec();
    wait_hit("post_rst");
    check("post_rst_inst", last_inst, 32'h00100513);

    // Random traffic: mostly held pcs from a small pool, occasional ce drop / jumpout
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(4))
          0: pc = 32'h0;
          1: pc = 32'h4;
          2: pc = 32'h8;
          3: pc = 32'hFFFF_FFFD;
          default: pc = $urandom;
        endcase
      end
      ce      = ($urandom_range(9) != 0);
      jumpout = ($urandom_range(15) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_resp.md
Name: inst_fetch_resp

Overview:
Instruction-fetch responder. It serves the pc/ce request issued by the PC register and returns a 32-bit instruction to if_id. The external memory port is one byte wide, so the block assembles each instruction from four sequential byte reads (little-endian). It requests a pipeline stall through ctrl while a fetch is outstanding, and keeps a one-entry instruction buffer so a stalled, unchanged pc is not refetched.

Parameters:
ADDR_W, 32, width of pc and mem_addr
INST_W, 32, instruction width (fixed at 4 bytes)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
pc  in  ADDR_W  requested instruction address, from the PC register
ce  in  1  fetch enable, from the PC register; 1 = request valid
jumpout  in  1  branch redirect from ex; aborts any fetch in flight
mem_din  in  8  read data; holds the byte addressed in the previous cycle
mem_addr  out  ADDR_W  byte address to memory
mem_rd_en  out  1  memory read strobe
inst  out  INST_W  instruction to if_id; 0 when inst_valid=0
inst_valid  out  1  inst corresponds to the current pc
stall_req  out  1  stall request to ctrl

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tag_valid=0, tag=0, buf=0, shadow=0. Outputs: mem_rd_en=0, mem_addr=0, inst=0, inst_valid=0, stall_req=0.
- States are IDLE, RD0, RD1, RD2, RD3, LAST. A register req_pc is latched on leaving IDLE.
- hit = ce & tag_valid & (pc==tag) & (state==IDLE). This is combinational.
- inst_valid = hit. inst = hit ? buf : 0.
- stall_req = ce & ~hit. Because it is combinational, it is high in the same cycle a miss is first seen.
- IDLE transitions:
  - If ce=1 and not hit: latch req_pc=pc and go to RD0.
  - Otherwise stay in IDLE.
- Read states:
  - RDk (k=0..3) drives mem_rd_en=1 and mem_addr=req_pc+k, computed modulo 2^ADDR_W (wrap-around is allowed).
  - RD1..RD3 and LAST capture mem_din into shadow byte k-1 (LAST captures byte 3).
  - In LAST: mem_rd_en=0. On the closing edge, buf = {b3,b2,b1,b0}, tag=req_pc, tag_valid=1, state goes to IDLE.
- Outside the RD states, mem_rd_en=0 and mem_addr=0.
- Miss latency: the miss is seen in cycle T. Bytes are issued in T+1..T+4, and the commit happens at the end of T+5. With pc held, hit (inst_valid=1, stall_req=0) occurs in T+6. That is 6 cycles of stall_req.
- Abort: jumpout=1 or ce=0 in any non-IDLE state sends the state to IDLE on the next edge.
  - The shadow register is discarded; buf, tag and tag_valid are unchanged.
  - The abort has priority over the LAST commit.
  - In the abort cycle itself, the RD-state outputs are still driven as normal.
- jumpout in IDLE has no special effect. The new pc is simply compared next cycle.
- If pc changes mid-fetch without jumpout, the fetch completes for req_pc and commits. IDLE then re-evaluates the new pc, which normally misses and refetches.
- Misaligned pc (pc[1:0]!=0) needs no special handling; it fetches pc..pc+3.
- tag_valid is cleared only by reset. The block does not support self-modifying code.
- A reset asserted mid-fetch returns the block to the reset values immediately, without waiting for a clock edge.

Test Plan:
1. Cold miss. Memory[0..3] = 13 05 10 00. Release reset, ce=1, pc=0, and hold pc. Required: stall_req=1 for 6 cycles; mem_addr sequence 0,1,2,3; then inst=0x00100513, inst_valid=1, stall_req=0.
2. Hit. Continuing from test 1, hold pc=0 for 5 cycles. Required: inst_valid=1 every cycle, mem_rd_en=0 throughout.
3. New pc. Switch to pc=4 with memory[4..7] = 93 05 20 00. Required: inst_valid drops the same cycle; 6-cycle stall; then inst=0x00200593.
4. Jump abort. Start a fetch at pc=8 and pulse jumpout=1 with pc=0 during RD2. Required: next cycle state=IDLE and mem_rd_en=0. pc=0 misses, because tag is still 4. Refetch returns 0x00100513.
5. Wrap-around. pc=0xFFFFFFFE. Required: mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001, with bytes assembled in that order.
6. Reset mid-fetch. Drive rst=0 during RD1, between clock edges. Required: mem_rd_en, stall_req and inst_valid go to 0 immediately. After release, pc=0 misses, because tag_valid was cleared.
